// File: rtl/cpu_run_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_run_controller_if
//   Dump stream from the run controller to a sink: one word per accepted beat,
//   tagged with its section (register file or data memory) and a last flag.
//
//   Signals
//     dump_valid   master -> slave   beat valid
//     dump_ready   slave  -> master  sink accepts the beat this cycle
//     dump_data    master -> slave   beat payload, DATA_W bits
//     dump_is_mem  master -> slave   0 = register beat, 1 = memory beat
//     dump_last    master -> slave   final beat of the memory section
//
//   DATA_W must match the DATA_W of the cpu_run_controller it is bound to.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface cpu_run_controller_if #(
    parameter int DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_is_mem;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_is_mem,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_is_mem,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//   Run/dump sequencer around a pipelined core. On start it holds the core in
//   reset for BOOT_CYCLES, releases it and counts cycles until end_program,
//   lets the pipeline drain for DRAIN_CYCLES, then streams NUM_REGS register
//   words followed by MEM_WORDS data-memory words over a valid/ready port.
//
//   Optional feature: define RUN_WATCHDOG_EN to abort a run that reaches
//   MAX_CYCLES without end_program (sets a sticky timeout, dump still runs).
//
//   Ports
//     clk           in   clock
//     reset         in   asynchronous, active-low reset
//     start         in   1-cycle pulse, honoured in IDLE and DONE only
//     end_program   in   halt indication from the core
//     cpu_reset_n   out  reset to the core, active low
//     reg_addr      out  register-file read index
//     reg_data      in   combinational register read data for reg_addr
//     mem_addr      out  data-memory word index
//     mem_data      in   combinational memory read data for mem_addr
//     dump          if   dump stream (master side of cpu_run_controller_if)
//     cycle_count   out  cycles spent in RUN, saturating
//     busy          out  high from BOOT through DUMP_MEM
//     done          out  high in DONE
//     timeout       out  watchdog fired, sticky until the next start
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_run_controller #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 5,
    parameter int NUM_REGS     = 32,
    parameter int MEM_WORDS    = 32,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 4096
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic                                            end_program,
    output logic                                            cpu_reset_n,
    output logic [((NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1)-1:0] reg_addr,
    input  logic [DATA_W-1:0]                               reg_data,
    output logic [((MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1)-1:0] mem_addr,
    input  logic [DATA_W-1:0]                               mem_data,
    cpu_run_controller_if.master                            dump,
    output logic [CNT_W-1:0]                                cycle_count,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            timeout
);

    localparam int RA_W    = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1;
    localparam int MA_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int MAX_SEC = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
    // The index must be able to hold MEM_WORDS: that value marks "all memory
    // beats loaded" while the last one waits for acceptance.
    localparam int IDX_W   = $clog2(MAX_SEC + 1);
    localparam int BOOT_W  = (BOOT_CYCLES  > 0) ? $clog2(BOOT_CYCLES  + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

`ifdef RUN_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    if (NUM_REGS < 1 || MEM_WORDS < 1) begin : g_bad_cfg
        $error("cpu_run_controller: NUM_REGS and MEM_WORDS must both be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        RUN,
        DRAIN,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [BOOT_W-1:0]   boot_cnt_q,  boot_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                timeout_q,   timeout_d;
    logic                valid_q,     valid_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic                is_mem_q,    is_mem_d;
    logic                last_q,      last_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                load_ok;

    // Where RUN goes once it ends; a zero drain depth skips DRAIN entirely.
    localparam state_t AFTER_RUN = (DRAIN_CYCLES > 0) ? DRAIN : DUMP_REG;
    localparam state_t AFTER_START = (BOOT_CYCLES > 0) ? BOOT : RUN;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        drain_cnt_d = drain_cnt_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        valid_d     = valid_q;
        data_d      = data_q;
        is_mem_d    = is_mem_q;
        last_d      = last_q;

        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        // A new beat may be loaded when the output slot is empty or being drained.
        load_ok = !valid_q || dump.dump_ready;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = AFTER_START;
                    boot_cnt_d = '0;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                    idx_d      = '0;
                end
            end

            BOOT: begin
                if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
                    state_d    = RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end

            RUN: begin
                // The cycle in which end_program is sampled still counts.
                cnt_d = cnt_inc;
                if (end_program) begin
                    state_d     = AFTER_RUN;
                    drain_cnt_d = '0;
                end else if (WD_EN && (cnt_inc >= CNT_W'(MAX_CYCLES))) begin
                    state_d     = AFTER_RUN;
                    drain_cnt_d = '0;
                    timeout_d   = 1'b1;
                end
            end

            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d     = DUMP_REG;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            DUMP_REG: begin
                if (load_ok) begin
                    data_d   = reg_data;
                    valid_d  = 1'b1;
                    is_mem_d = 1'b0;
                    last_d   = 1'b0;
                    // Switching sections on the load of the final register
                    // lets the first memory word follow without a bubble.
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        idx_d   = '0;
                        state_d = DUMP_MEM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            DUMP_MEM: begin
                if (valid_q && dump.dump_ready && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = DONE;
                end else if (load_ok && (idx_q < IDX_W'(MEM_WORDS))) begin
                    data_d   = mem_data;
                    valid_d  = 1'b1;
                    is_mem_d = 1'b1;
                    last_d   = (idx_q == IDX_W'(MEM_WORDS - 1));
                    idx_d    = idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            boot_cnt_q  <= '0;
            drain_cnt_q <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            is_mem_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous cycle, regardless of order.
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            is_mem_q    <= is_mem_d;
            last_q      <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The core stays out of reset once released, including DONE, so its state
    // remains inspectable after the dump.
    assign cpu_reset_n = (state_q == RUN)      || (state_q == DRAIN) ||
                         (state_q == DUMP_REG) || (state_q == DUMP_MEM) ||
                         (state_q == DONE);
    assign busy        = (state_q == BOOT)     || (state_q == RUN)   ||
                         (state_q == DRAIN)    || (state_q == DUMP_REG) ||
                         (state_q == DUMP_MEM);
    assign done        = (state_q == DONE);
    assign cycle_count = cnt_q;
    assign timeout     = WD_EN ? timeout_q : 1'b0;

    assign reg_addr    = idx_q[RA_W-1:0];
    assign mem_addr    = idx_q[MA_W-1:0];

    assign dump.dump_valid  = valid_q;
    assign dump.dump_data   = data_q;
    assign dump.dump_is_mem = is_mem_q;
    assign dump.dump_last   = last_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_controller
//   Directed bench for cpu_run_controller. A phase-level model predicts, every
//   cycle, the control outputs and which dump beat must be presented; a single
//   compare process checks the DUT against it. Register and memory contents are
//   synthetic functions of the address so every beat has a known payload.
//   Build with +define+RUN_WATCHDOG_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cpu_run_controller;

    localparam int NR    = 32;
    localparam int NM    = 32;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int BOOT  = 2;
    localparam int DRAIN = 5;
    localparam int MAXC  = 16;
    localparam int TOTAL = NR + NM;

`ifdef RUN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          end_program = 1'b0;
    logic          cpu_reset_n;
    logic [4:0]    reg_addr;
    logic [4:0]    mem_addr;
    logic [DW-1:0] reg_data;
    logic [DW-1:0] mem_data;
    logic [CW-1:0] cycle_count;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   salt = 32'h0;

    cpu_run_controller_if #(.DATA_W(DW)) dump_bus ();

    cpu_run_controller #(
        .BOOT_CYCLES (BOOT),
        .DRAIN_CYCLES(DRAIN),
        .NUM_REGS    (NR),
        .MEM_WORDS   (NM),
        .DATA_W      (DW),
        .CNT_W       (CW),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .end_program(end_program),
        .cpu_reset_n(cpu_reset_n),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .dump       (dump_bus),
        .cycle_count(cycle_count),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Synthetic core contents.
    assign reg_data = (32'h1000_0000 + 32'(reg_addr) * 32'h0000_0101) ^ salt;
    assign mem_data = (32'hC0DE_0000 + 32'(mem_addr) * 32'h0000_0007) ^ salt;

    function automatic logic [31:0] beat_word(int k, logic [31:0] s);
        if (k < NR) return (32'h1000_0000 + 32'(k) * 32'h0000_0101) ^ s;
        return (32'hC0DE_0000 + 32'(k - NR) * 32'h0000_0007) ^ s;
    endfunction

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-run statistics collected by the compare process.
    int n_acc;
    int first_mem;
    int last_at;
    int cur_streak;
    int max_streak;

    task automatic clear_stats();
        n_acc      = 0;
        first_mem  = -1;
        last_at    = -1;
        cur_streak = 0;
        max_streak = 0;
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: phase, countdown, expected beat index
    // -------------------------------------------------------------------------
    typedef enum int {P_IDLE, P_BOOT, P_RUN, P_DRAIN, P_DUMP, P_DONE} phase_t;

    phase_t      m_phase = P_IDLE;
    int          m_left  = 0;
    logic [31:0] m_count = 32'h0;
    logic        m_to    = 1'b0;
    int          m_beat  = 0;
    bit          m_first = 1'b0;

    initial begin
        clear_stats();
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_phase = P_IDLE;
                m_left  = 0;
                m_count = 32'h0;
                m_to    = 1'b0;
                m_beat  = 0;
                m_first = 1'b0;
            end
            model_compare();
            if (reset) model_advance();
        end
    end

    task automatic model_compare();
        logic exp_rstn;
        logic exp_busy;
        logic exp_valid;
        exp_rstn  = (m_phase == P_RUN) || (m_phase == P_DRAIN) ||
                    (m_phase == P_DUMP) || (m_phase == P_DONE);
        exp_busy  = (m_phase == P_BOOT) || (m_phase == P_RUN) ||
                    (m_phase == P_DRAIN) || (m_phase == P_DUMP);
        // The first dump cycle only loads; afterwards valid stays up until the
        // final beat is accepted, whatever the sink does.
        exp_valid = (m_phase == P_DUMP) && !m_first;

        check("cpu_reset_n", 64'(cpu_reset_n), 64'(exp_rstn));
        check("busy",        64'(busy),        64'(exp_busy));
        check("done",        64'(done),        64'(m_phase == P_DONE));
        check("timeout",     64'(timeout),     64'(m_to));
        check("cycle_count", 64'(cycle_count), 64'(m_count));
        check("dump_valid",  64'(dump_bus.dump_valid), 64'(exp_valid));

        if (exp_valid) begin
            check("dump_data",   64'(dump_bus.dump_data),   64'(beat_word(m_beat, salt)));
            check("dump_is_mem", 64'(dump_bus.dump_is_mem), 64'(m_beat >= NR));
            check("dump_last",   64'(dump_bus.dump_last),   64'(m_beat == TOTAL - 1));
            if (dump_bus.dump_ready) begin
                if (dump_bus.dump_is_mem && first_mem < 0) first_mem = n_acc;
                if (dump_bus.dump_last) last_at = n_acc;
                n_acc++;
            end
        end
        if (!reset) begin
            check("rst dump_data",   64'(dump_bus.dump_data),   64'h0);
            check("rst dump_is_mem", 64'(dump_bus.dump_is_mem), 64'h0);
            check("rst dump_last",   64'(dump_bus.dump_last),   64'h0);
        end

        if (dump_bus.dump_valid) begin
            cur_streak++;
            if (cur_streak > max_streak) max_streak = cur_streak;
        end else begin
            cur_streak = 0;
        end
    endtask

    task automatic model_advance();
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (start) begin
                    m_phase = P_BOOT;
                    m_left  = BOOT;
                    m_count = 32'h0;
                    m_to    = 1'b0;
                    m_beat  = 0;
                end
            end
            P_BOOT: begin
                m_left--;
                if (m_left == 0) m_phase = P_RUN;
            end
            P_RUN: begin
                if (m_count != 32'hFFFF_FFFF) m_count++;
                if (end_program) begin
                    m_phase = P_DRAIN;
                    m_left  = DRAIN;
                end else if (WD && m_count >= 32'(MAXC)) begin
                    m_phase = P_DRAIN;
                    m_left  = DRAIN;
                    m_to    = 1'b1;
                end
            end
            P_DRAIN: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_DUMP;
                    m_first = 1'b1;
                    m_beat  = 0;
                end
            end
            P_DUMP: begin
                if (m_first) begin
                    m_first = 1'b0;
                end else if (dump_bus.dump_ready) begin
                    if (m_beat == TOTAL - 1) m_phase = P_DONE;
                    else m_beat++;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // -------------------------------------------------------------------------
    bit rand_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) dump_bus.dump_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_run();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cpu_reset_n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("reached RUN", 64'(ok), 64'h1);
    endtask

    // Called in RUN cycle 1; end_program is high during RUN cycle n.
    // With glitch set, a start pulse is offered in RUN cycle 1.
    task automatic run_for(int n, bit glitch);
        if (glitch) begin
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (n - 2) step();
        end else begin
            repeat (n - 1) step();
        end
        end_program = 1'b1;
        step();
        end_program = 1'b0;
    endtask

    task automatic wait_done(int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("reached DONE", 64'(ok), 64'h1);
    endtask

    task automatic check_dump(string tag);
        check({tag, " beats"},     64'(n_acc),     64'd64);
        check({tag, " first_mem"}, 64'(first_mem), 64'd32);
        check({tag, " last_at"},   64'(last_at),   64'd63);
    endtask

    task automatic full_run(string tag, int n, bit glitch);
        clear_stats();
        pulse_start();
        check({tag, " count cleared"},   64'(cycle_count), 64'h0);
        check({tag, " timeout cleared"}, 64'(timeout),     64'h0);
        wait_run();
        run_for(n, glitch);
        wait_done(600);
        check({tag, " cycle_count"}, 64'(cycle_count), 64'(n));
        check({tag, " done"},        64'(done),        64'h1);
        check_dump(tag);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        dump_bus.dump_ready = 1'b1;

        // Reset state.
        #13;
        check("rst cpu_reset_n", 64'(cpu_reset_n),         64'h0);
        check("rst dump_valid",  64'(dump_bus.dump_valid), 64'h0);
        check("rst busy",        64'(busy),                64'h0);
        step();
        reset = 1'b1;
        repeat (2) step();

        // 1/2: end_program in RUN cycle 10, sink always ready.
        clear_stats();
        pulse_start();
        wait_run();
        run_for(10, 1'b0);
        lat = 0;
        while (!dump_bus.dump_valid && lat < 50) begin
            step();
            lat++;
        end
        // Five drain cycles plus the one-cycle load of the first beat.
        check("T1 drain to first beat", 64'(lat), 64'd6);
        wait_done(600);
        check("T1 cycle_count", 64'(cycle_count), 64'd10);
        check("T1 done",        64'(done),        64'h1);
        check("T2 valid streak", 64'(max_streak), 64'd64);
        check_dump("T1");

        // 3/6: random back-pressure, start ignored in RUN, end_program ignored in DUMP.
        salt       = 32'h5A5A_1234;
        rand_ready = 1'b1;
        clear_stats();
        pulse_start();
        wait_run();
        run_for(7, 1'b1);
        lat = 0;
        while (!dump_bus.dump_valid && lat < 50) begin
            step();
            lat++;
        end
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        wait_done(600);
        check("T3 cycle_count", 64'(cycle_count), 64'd7);
        check_dump("T3");

        // 6: restart from DONE with the T1 setup reproduces T1.
        salt                = 32'h0;
        rand_ready          = 1'b0;
        dump_bus.dump_ready = 1'b1;
        full_run("T6", 10, 1'b0);
        check("T6 valid streak", 64'(max_streak), 64'd64);

        // 4: asynchronous reset in the middle of the memory section.
        salt       = 32'h0BAD_F00D;
        rand_ready = 1'b1;
        clear_stats();
        pulse_start();
        wait_run();
        run_for(12, 1'b0);
        lat = 0;
        while (!(dump_bus.dump_valid && dump_bus.dump_is_mem) && lat < 400) begin
            step();
            lat++;
        end
        check("T4 reached mem section", 64'(dump_bus.dump_is_mem), 64'h1);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        check("T4 cpu_reset_n",  64'(cpu_reset_n),          64'h0);
        check("T4 dump_valid",   64'(dump_bus.dump_valid),  64'h0);
        check("T4 dump_data",    64'(dump_bus.dump_data),   64'h0);
        check("T4 dump_is_mem",  64'(dump_bus.dump_is_mem), 64'h0);
        check("T4 dump_last",    64'(dump_bus.dump_last),   64'h0);
        check("T4 cycle_count",  64'(cycle_count),          64'h0);
        check("T4 busy",         64'(busy),                 64'h0);
        check("T4 done",         64'(done),                 64'h0);
        repeat (2) step();
        reset = 1'b1;
        step();
        full_run("T4 restart", 10, 1'b0);

        // 5: watchdog (or its absence) and end_program exactly at MAX_CYCLES.
        rand_ready          = 1'b0;
        dump_bus.dump_ready = 1'b1;
        clear_stats();
        pulse_start();
        wait_run();
`ifdef RUN_WATCHDOG_EN
        wait_done(600);
        check("T5 timeout",     64'(timeout),     64'h1);
        check("T5 cycle_count", 64'(cycle_count), 64'd16);
        check_dump("T5");
`else
        repeat (39) step();
        check("T5 no timeout",  64'(timeout),     64'h0);
        check("T5 still busy",  64'(busy),        64'h1);
        check("T5 cycle_count", 64'(cycle_count), 64'd39);
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        wait_done(600);
        check("T5 final count", 64'(cycle_count), 64'd40);
        check_dump("T5");
`endif
        full_run("T5 tie", MAXC, 1'b0);
        check("T5 tie timeout", 64'(timeout), 64'h0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global time limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
